// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t       : FSM encoding (IDLE / RUN / FIX), 2 bits
//   DEFAULT_WIDTH : default operand width
//   cntWidth()    : bits needed for an iteration counter that reaches w
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // The counter must be able to hold the value w itself, hence w+1.
    function automatic int cntWidth(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// ---------------------------------------------------------------------------
// shift_add_step
// One combinational shift-and-add iteration: conditionally adds the
// multiplicand into the upper half of the accumulator.
//   i_accHi   : current accumulator upper half
//   i_mcand   : multiplicand magnitude
//   i_mplrLsb : current multiplier LSB (selects add or pass-through)
//   o_accHi   : low WIDTH bits of the sum
//   o_carry   : carry out of the WIDTH+1 bit adder
// ---------------------------------------------------------------------------
module shift_add_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_accHi,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic             i_mplrLsb,
    output logic [WIDTH-1:0] o_accHi,
    output logic             o_carry
);

    logic [WIDTH-1:0] w_addend;

    // The adder is one bit wider than the operands so the carry is kept
    // and can be shifted back into the accumulator MSB by the caller.
    always_comb begin
        w_addend = i_mplrLsb ? i_mcand : '0;
        {o_carry, o_accHi} = {1'b0, i_accHi} + {1'b0, w_addend};
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// seq_shift_add_mult
// Multi-cycle signed/unsigned shift-and-add multiplier, one multiplier bit
// per clock, with a start/busy/done handshake.
//   i_clk       : rising-edge clock
//   i_rst       : asynchronous active-high reset
//   i_start     : request, only honoured in IDLE
//   i_is_signed : 1 = two's-complement operands, sampled with i_start
//   i_a, i_b    : multiplicand / multiplier, sampled with i_start
//   o_busy      : high while iterating
//   o_done      : one-cycle pulse when o_result becomes valid
//   o_result    : 2*WIDTH-bit product, held until the next o_done
// ---------------------------------------------------------------------------
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_is_signed,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam int CW = cntWidth(WIDTH);

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [WIDTH-1:0]   r_acc;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_sumLo;
    logic               w_carry;
    logic               w_runDone;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [2*WIDTH-1:0] w_prod;

    shift_add_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_accHi   (r_acc),
        .i_mcand   (r_mcand),
        .i_mplrLsb (r_mplr[0]),
        .o_accHi   (w_sumLo),
        .o_carry   (w_carry)
    );

    // Operands are reduced to magnitudes so the core only ever does an
    // unsigned multiply. -2^(W-1) negates to itself, which read unsigned
    // is exactly its magnitude, so no extra bit is needed.
    assign w_absA    = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_absB    = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_prod    = {r_acc, r_mplr};
    assign w_runDone = (r_cnt == CW'(WIDTH));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; RUN spends WIDTH iterations plus one edge that
    // loads the signed-corrected result, so latency never depends on data.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_start)   w_nextState = RUN;
            RUN:     if (w_runDone) w_nextState = FIX;
            FIX:                    w_nextState = IDLE;
            default:                w_nextState = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        o_busy = (r_state == RUN);
        o_done = (r_state == FIX);
    end

    assign o_result = r_result;

    // Datapath. During RUN the multiplier register doubles as the low half
    // of the product: each iteration shifts {carry, acc, mplr} right by one,
    // so after WIDTH steps {acc, mplr} holds the full unsigned product.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand <= w_absA;
                        r_mplr  <= w_absB;
                        r_neg   <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!w_runDone) begin
                        r_acc  <= {w_carry, w_sumLo[WIDTH-1:1]};
                        r_mplr <= {w_sumLo[0], r_mplr[WIDTH-1:1]};
                        r_cnt  <= r_cnt + CW'(1);
                    end else begin
                        r_result <= r_neg ? -w_prod : w_prod;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_mult
// Directed and random checks of the multiplier at WIDTH=32 and WIDTH=8
// against plain-arithmetic reference products.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_mult;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        start = 1'b0;
   logic        isSigned = 1'b0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic        busy;
   logic        done;
   logic [63:0] result;

   logic        start8 = 1'b0;
   logic        isSigned8 = 1'b0;
   logic [7:0]  opA8 = '0;
   logic [7:0]  opB8 = '0;
   logic        busy8;
   logic        done8;
   logic [15:0] result8;

   int testsRun = 0;
   int failCount = 0;

   seq_shift_add_mult #(.WIDTH(32)) dut (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_start     (start),
      .i_is_signed (isSigned),
      .i_a         (opA),
      .i_b         (opB),
      .o_busy      (busy),
      .o_done      (done),
      .o_result    (result)
   );

   seq_shift_add_mult #(.WIDTH(8)) dut8 (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_start     (start8),
      .i_is_signed (isSigned8),
      .i_a         (opA8),
      .i_b         (opB8),
      .o_busy      (busy8),
      .o_done      (done8),
      .o_result    (result8)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Reference products computed with ordinary integer multiplication.
   function automatic logic [63:0] refMul32(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      longint prod;
      if (sgn) prod = longint'($signed(a)) * longint'($signed(b));
      else     prod = longint'({32'b0, a}) * longint'({32'b0, b});
      return 64'(prod);
   endfunction

   function automatic logic [15:0] refMul8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
      int prod;
      if (sgn) prod = int'($signed(a)) * int'($signed(b));
      else     prod = int'({24'b0, a}) * int'({24'b0, b});
      return 16'(prod);
   endfunction

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents an operation for one edge, then scrambles the inputs to show
   // they are not needed after the start cycle.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      start    = 1'b1;
      opA      = a;
      opB      = b;
      isSigned = sgn;
      @(posedge clock); #1;
      start    = 1'b0;
      opA      = $urandom;
      opB      = $urandom;
      isSigned = 1'($urandom);
   endtask

   // Full 32-bit operation: latency, busy, done pulse and product. A second
   // start can be injected injectAt cycles into the run; it must be ignored.
   task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn, input int injectAt);
      logic [63:0] expected;
      int          n;
      logic        gotDone;
      expected = refMul32(a, b, sgn);
      applyStimulus(a, b, sgn);
      n = 0;
      gotDone = 1'b0;
      while (!gotDone && n < 60) begin
         if (n + 1 == injectAt) begin
            start = 1'b1; opA = -32'sd3; opB = 32'd3; isSigned = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clock); #1;
         n++;
         if (n == 1) checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
         if (done) gotDone = 1'b1;
      end
      start = 1'b0;
      checkOutput({tag, "_lat"}, 64'(n), 64'd33);
      checkOutput({tag, "_res"}, result, expected);
      checkOutput({tag, "_busyAtDone"}, 64'(busy), 64'd0);
      @(posedge clock); #1;
      checkOutput({tag, "_donePulse"}, 64'(done), 64'd0);
      checkOutput({tag, "_hold"}, result, expected);
   endtask

   task automatic runOp8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sgn);
      logic [15:0] expected;
      int          n;
      expected  = refMul8(a, b, sgn);
      start8    = 1'b1;
      opA8      = a;
      opB8      = b;
      isSigned8 = sgn;
      @(posedge clock); #1;
      start8    = 1'b0;
      opA8      = 8'($urandom);
      opB8      = 8'($urandom);
      n = 0;
      while (!done8 && n < 30) begin
         @(posedge clock); #1;
         n++;
      end
      checkOutput({tag, "_lat"}, 64'(n), 64'd9);
      checkOutput({tag, "_res"}, 64'(result8), 64'(expected));
      @(posedge clock); #1;
   endtask

   initial begin
      int   n;
      logic sawDone;

      // Reset state.
      @(posedge clock); @(posedge clock); #1;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_result", result, 64'd0);
      checkOutput("rst_result8", 64'(result8), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      // Signed directed cases.
      runOp("s_50x-40", 32'd50, -32'sd40, 1'b1, 0);
      checkOutput("s_50x-40_lit", result, 64'hFFFFFFFF_FFFFF830);
      runOp("s_-80x-65", -32'sd80, -32'sd65, 1'b1, 0);
      checkOutput("s_-80x-65_lit", result, 64'd5200);
      runOp("s_-999x999", -32'sd999, 32'd999, 1'b1, 0);
      runOp("s_98765x1", 32'd98765, 32'd1, 1'b1, 0);
      runOp("s_98756x0", 32'd98756, 32'd0, 1'b1, 0);
      checkOutput("s_zero_lit", result, 64'd0);
      runOp("s_min2", 32'h80000000, 32'h80000000, 1'b1, 0);
      checkOutput("s_min2_lit", result, 64'h40000000_00000000);
      runOp("s_maxxmin", 32'h7FFFFFFF, 32'h80000000, 1'b1, 0);
      checkOutput("s_maxxmin_lit", result, 64'hC0000000_80000000);

      // Unsigned directed cases.
      runOp("u_max2", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
      checkOutput("u_max2_lit", result, 64'hFFFFFFFE_00000001);
      runOp("u_maxx2", 32'hFFFFFFFF, 32'd2, 1'b0, 0);
      checkOutput("u_maxx2_lit", result, 64'h00000001_FFFFFFFE);

      // Start during RUN is ignored; then back-to-back start right after done.
      runOp("hs_50x70", 32'd50, 32'd70, 1'b0, 10);
      checkOutput("hs_first_lit", result, 64'd3500);
      @(posedge clock); #1;
      checkOutput("hs_noQueue_busy", 64'(busy), 64'd0);
      runOp("hs_-3x3", -32'sd3, 32'd3, 1'b1, 0);
      checkOutput("hs_second_lit", result, -64'sd9);

      // Reset in the middle of a run discards the operation.
      applyStimulus(32'd1234, 32'd5678, 1'b0);
      for (int i = 0; i < 14; i++) begin
         @(posedge clock);
      end
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      checkOutput("midrst_result", result, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done) sawDone = 1'b1;
      end
      checkOutput("midrst_noDone", 64'(sawDone), 64'd0);
      runOp("post_6x7", 32'd6, 32'd7, 1'b1, 0);
      checkOutput("post_6x7_lit", result, 64'd42);

      // Random operands, biased toward extreme values.
      for (int i = 0; i < 20; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hFFFFFFFF;
         if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h00000000;
         runOp($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 0);
      end

      // Narrow instance.
      runOp8("w8_s_min2", 8'h80, 8'h80, 1'b1);
      checkOutput("w8_s_min2_lit", 64'(result8), 64'h4000);
      runOp8("w8_s_50x-40", 8'd50, 8'hD8, 1'b1);
      checkOutput("w8_s_50x-40_lit", 64'(result8), 64'hF830);
      runOp8("w8_s_maxxmin", 8'h7F, 8'h80, 1'b1);
      runOp8("w8_u_max2", 8'hFF, 8'hFF, 1'b0);
      checkOutput("w8_u_max2_lit", 64'(result8), 64'hFE01);
      runOp8("w8_u_maxx2", 8'hFF, 8'd2, 1'b0);
      runOp8("w8_zero", 8'd0, 8'h9C, 1'b1);
      for (int i = 0; i < 10; i++) begin
         runOp8($sformatf("w8_rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
      end

      n = testsRun;
      $display("[TB] %0d tests run, %0d failed", n, failCount);
      $finish;
   end

endmodule
